// File: rtl/sram_arb_ctrl_if.sv
// Channel-side bus of sram_arb_ctrl: per-channel request/command fields,
// one-hot completion pulses and shared read-data / busy status.
interface sram_arb_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]          ch_req;
  logic [NUM_CH-1:0]          ch_wr;
  logic [NUM_CH*ADDR_W-1:0]   ch_addr;
  logic [NUM_CH*DATA_W-1:0]   ch_din;
  logic [NUM_CH*DATA_W/8-1:0] ch_be;
  logic [NUM_CH-1:0]          ch_ack;
  logic [DATA_W-1:0]          rd_data;
  logic                       busy;

  modport master (
    output ch_req, ch_wr, ch_addr, ch_din, ch_be,
    input  ch_ack, rd_data, busy
  );

  modport slave (
    input  ch_req, ch_wr, ch_addr, ch_din, ch_be,
    output ch_ack, rd_data, busy
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Async-SRAM controller with an N-channel round-robin front end and separate
// read/write wait states. Optional read->write TURN cycle: SRAM_ARB_CTRL_TURNAROUND_EN.
module sram_arb_ctrl #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_arb_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0]     sram_addr,
  inout  wire  [DATA_W-1:0]     sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n
);

  localparam int BE_W  = DATA_W / 8;
  localparam int MAX_W = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, TURN, SETUP, ACCESS, HOLD} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt;
  logic               wr_q;
  logic [BE_W-1:0]    be_q;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]  dq_out;
  logic               dq_oe;
  logic [NUM_CH-1:0]  ack_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               busy_q;

  // Round-robin pick
  logic               found;
  logic [PTR_W-1:0]   sel;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_din;
  logic [BE_W-1:0]    sel_be;

  // Next values of the registered pins
  logic               op_wr;
  logic [BE_W-1:0]    op_be;
  logic               ce_d, oe_d, we_d, dq_oe_d;
  logic [BE_W-1:0]    be_n_d;
  logic [NUM_CH-1:0]  ack_d;

`ifdef SRAM_ARB_CTRL_TURNAROUND_EN
  logic               prev_rd;
`endif

  always_comb begin
    int unsigned     idx;
    logic [PTR_W-1:0] cand;
    found = 1'b0;
    sel   = rr_ptr;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx  = (32'(rr_ptr) + i) % NUM_CH;
      cand = PTR_W'(idx);
      if (!found && bus.ch_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    sel_wr   = bus.ch_wr[sel];
    sel_addr = bus.ch_addr[sel*ADDR_W +: ADDR_W];
    sel_din  = bus.ch_din[sel*DATA_W +: DATA_W];
    sel_be   = bus.ch_be[sel*BE_W +: BE_W];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
`ifdef SRAM_ARB_CTRL_TURNAROUND_EN
        if (found) state_nxt = (sel_wr && prev_rd) ? TURN : SETUP;
`else
        if (found) state_nxt = SETUP;
`endif
      end
      TURN:  state_nxt = SETUP;
      SETUP: begin
        state_nxt = ACCESS;
        cnt_nxt   = wr_q ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT - 1);
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = HOLD;
        else           cnt_nxt   = cnt - 1'b1;
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pins are registered, so they are decoded from the state being entered;
  // on the grant edge the command comes straight from the selected channel.
  always_comb begin
    op_wr   = (state == IDLE) ? sel_wr : wr_q;
    op_be   = (state == IDLE) ? sel_be : be_q;
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    dq_oe_d = 1'b0;
    be_n_d  = '1;
    ack_d   = '0;
    case (state_nxt)
      SETUP: begin
        ce_d    = 1'b0;
        be_n_d  = ~op_be;
        oe_d    = op_wr;
        dq_oe_d = op_wr;
      end
      ACCESS: begin
        ce_d    = 1'b0;
        be_n_d  = ~op_be;
        oe_d    = op_wr;
        we_d    = ~op_wr;
        dq_oe_d = op_wr;
      end
      HOLD: begin
        ce_d       = 1'b0;
        be_n_d     = ~op_be;
        dq_oe_d    = op_wr;
        ack_d[gnt] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PTR_W'(NUM_CH - 1);
      gnt       <= '0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      cnt       <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      ack_q     <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sram_ce_n <= ce_d;
      sram_oe_n <= oe_d;
      sram_we_n <= we_d;
      sram_be_n <= be_n_d;
      dq_oe     <= dq_oe_d;
      ack_q     <= ack_d;
      busy_q    <= (state_nxt != IDLE);
      if (state == IDLE && found) begin
        gnt       <= sel;
        rr_ptr    <= sel;
        wr_q      <= sel_wr;
        be_q      <= sel_be;
        sram_addr <= sel_addr;
        dq_out    <= sel_din;
      end
      if (state == ACCESS && cnt == '0 && !wr_q)
        rd_data_q <= sram_dq;
    end
  end

`ifdef SRAM_ARB_CTRL_TURNAROUND_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  prev_rd <= 1'b0;
    else if (state == ACCESS && cnt == '0)    prev_rd <= ~wr_q;
  end
`endif

  assign sram_dq     = dq_oe ? dq_out : 'z;
  assign bus.ch_ack  = ack_q;
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;

endmodule
